// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS boot path.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } loader_state_t;

  localparam int WORD_W     = 32;
  localparam int BYTE_SHIFT = 2;

  // Turn a word address into the word-aligned byte address seen by the memory.
  function automatic logic [WORD_W-1:0] word_to_byte_addr(input logic [WORD_W-1:0] word_addr);
    return word_addr << BYTE_SHIFT;
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Boot loader: streams instruction words into consecutive instruction-memory
// words while holding the core in reset, then releases the core.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int RST_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] checksum
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  loader_state_t     state_reg;
  loader_state_t     state_next;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        hold_reg;

  logic              start_ok;
  logic              handshake;
  logic [ADDR_W:0]   cnt_init;

  // A start pulse only counts when no session is in progress.
  assign start_ok  = start && ((state_reg == IDLE) || (state_reg == RUN));
  assign handshake = in_valid && in_ready;
  // Requests longer than the memory are clamped to one full pass.
  assign cnt_init  = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, RUN: begin
        if (start) begin
          state_next = (cnt_init == '0) ? HOLD : LOAD;
        end
      end
      LOAD: begin
        if (handshake && (cnt_reg == (ADDR_W+1)'(1))) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_reg == 4'd1) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status flags are pure state decodes (no path from in_valid).
  always_comb begin
    in_ready = (state_reg == LOAD);
    busy     = (state_reg == LOAD) || (state_reg == HOLD);
    done     = (state_reg == RUN);
  end

  // Datapath: write port, running checksum, word/hold counters, core reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      addr_reg   <= '0;
      hold_reg   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      checksum   <= '0;
      core_rst_n <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      // Core runs exactly while the loader sits in RUN.
      core_rst_n <= (state_next == RUN);
      if (start_ok) begin
        cnt_reg  <= cnt_init;
        addr_reg <= ADDR_W'(BASE_ADDR);
        checksum <= '0;
        hold_reg <= 4'(RST_HOLD);
      end else begin
        case (state_reg)
          LOAD: begin
            if (handshake) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_to_byte_addr(WORD_W'(addr_reg));
              mem_wdata <= in_data;
              checksum  <= checksum ^ in_data;
              // Word address wraps modulo DEPTH by its own width.
              addr_reg  <= addr_reg + 1'b1;
              cnt_reg   <= cnt_reg - 1'b1;
              hold_reg  <= 4'(RST_HOLD);
            end
          end
          HOLD: begin
            hold_reg <= hold_reg - 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader.
module tb_instr_mem_loader;

  localparam int ADDR_W    = 2;
  localparam int BASE_ADDR = 3;
  localparam int RST_HOLD  = 3;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;

  instr_mem_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .word_count(word_count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cs;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          write_cnt  = 0;
  bit          pat[6]     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] fix[3]     = '{32'h20080005, 32'h20090003, 32'h01095020};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      write_cnt++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no write expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("wr_checksum", checksum, e.cs);
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
        $display("write addr=0x%08h data=0x%08h cs=0x%08h", mem_addr, mem_wdata, checksum);
      end
    end
  end

  // Expected byte address of the idx-th word of a session.
  function automatic logic [31:0] model_addr(input int idx);
    return 32'(((BASE_ADDR + idx) % DEPTH) * 4);
  endfunction

  // mode 0: continuous, 1: fixed valid pattern, 2: random valid + stray starts.
  task automatic run_session(input int wc, input int mode, input bit fixed);
    int          n;
    int          idx;
    int          c;
    bit          v;
    logic [31:0] d;
    logic [31:0] cs;
    n = (wc > DEPTH) ? DEPTH : wc;
    write_cnt  = 0;
    word_count = (ADDR_W+1)'(wc);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("core_rst_n_after_start", 32'(core_rst_n), 32'd0);
    check("done_after_start", 32'(done), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    cs  = '0;
    idx = 0;
    c   = 0;
    while (idx < n && c < 200) begin
      check("in_ready_load", 32'(in_ready), 32'd1);
      case (mode)
        0:       v = 1'b1;
        1:       v = pat[c % 6];
        default: v = 1'($urandom % 2);
      endcase
      d          = fixed ? fix[idx] : $urandom;
      in_valid   = v;
      in_data    = d;
      start      = (mode == 2) && ($urandom % 6 == 0);
      word_count = (ADDR_W+1)'($urandom);
      if (v) begin
        cs ^= d;
        exp_q.push_back('{model_addr(idx), d, cs, cyc + 1});
        idx++;
      end
      c++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
    start    = 1'b0;
    check("words_loaded", 32'(idx), 32'(n));
    for (int h = 0; h < RST_HOLD; h++) begin
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_core_rst_n", 32'(core_rst_n), 32'd0);
      check("hold_done", 32'(done), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
      start      = (mode == 2) && ($urandom % 4 == 0);
      word_count = (ADDR_W+1)'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check("run_done", 32'(done), 32'd1);
    check("run_core_rst_n", 32'(core_rst_n), 32'd1);
    check("run_busy", 32'(busy), 32'd0);
    check("run_in_ready", 32'(in_ready), 32'd0);
    check("run_checksum", checksum, cs);
    check("write_count", 32'(write_cnt), 32'(n));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("session wc=%0d mode=%0d words=%0d checksum=0x%08h", wc, mode, n, checksum);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
    $display("reset check %s", tag);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_values("por");

    // Basic continuous load of the three-word program.
    run_session(3, 0, 1'b1);
    // Reload from RUN with backpressure.
    run_session(3, 1, 1'b1);
    // Zero-length session.
    run_session(0, 0, 1'b0);
    // Over-long request: clamped and wrapping.
    run_session(7, 0, 1'b0);

    // Mid-session reset after two of four words.
    write_cnt  = 0;
    word_count = (ADDR_W+1)'(4);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      logic [31:0] cs;
      logic [31:0] d;
      cs = '0;
      for (int i = 0; i < 2; i++) begin
        d = $urandom;
        in_valid = 1'b1;
        in_data  = d;
        cs ^= d;
        exp_q.push_back('{model_addr(i), d, cs, cyc + 1});
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_values("mid");
    check("mid_write_count", 32'(write_cnt), 32'd2);
    check("mid_queue_drained", 32'(exp_q.size()), 32'd0);

    // Randomized sessions, including ignored starts in LOAD and HOLD.
    for (int s = 0; s < 25; s++) begin
      run_session($urandom_range(0, 7), 2, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("run_stays", 32'(done), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
